// File: rtl/pdm_pcm_mod.sv
// First-order sigma-delta PCM-to-PDM modulator; packs C_NR_OF_BITS PDM bits MSB-first for the serializer.
// Optional LFSR dither on the accumulator carry-in when PDM_PCM_MOD_DITHER_EN is defined.
module pdm_pcm_mod #(
    parameter int C_NR_OF_BITS = 32,
    parameter int C_PCM_WIDTH  = 16,
    parameter int C_OSR        = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic [C_PCM_WIDTH-1:0]  pcm_data_i,
    input  logic                    pcm_valid_i,
    output logic                    pcm_ready_o,
    input  logic                    done_i,
    output logic [C_NR_OF_BITS-1:0] data_o,
    output logic                    pcm_underrun_o,
    output logic                    word_underrun_o
);

    localparam int BW = (C_NR_OF_BITS > 1) ? $clog2(C_NR_OF_BITS) : 1;
    localparam int OW = (C_OSR > 1) ? $clog2(C_OSR) : 1;

    // Alternating pattern with LSB set: 50% density, i.e. PDM silence.
    function automatic logic [C_NR_OF_BITS-1:0] mid_pattern();
        logic [C_NR_OF_BITS-1:0] m;
        for (int i = 0; i < C_NR_OF_BITS; i++) begin
            m[i] = ((i % 2) == 0);
        end
        return m;
    endfunction

    localparam logic [C_NR_OF_BITS-1:0] C_MID     = mid_pattern();
    localparam logic [C_PCM_WIDTH-1:0]  C_SIGN    = {1'b1, {(C_PCM_WIDTH-1){1'b0}}};
    localparam logic [BW-1:0]           C_BIT_END = BW'(C_NR_OF_BITS - 1);
    localparam logic [OW-1:0]           C_OSR_END = OW'(C_OSR - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic                    buf_valid;
    logic [C_PCM_WIDTH-1:0]  buf_dat;
    logic [C_PCM_WIDTH-1:0]  cur;
    logic [C_PCM_WIDTH-1:0]  acc;
    logic [OW-1:0]           osr_cnt;
    logic [BW-1:0]           bit_cnt;
    logic [C_NR_OF_BITS-1:0] staging;

    logic                    fill_act;
    logic                    word_take;
    logic                    word_miss;
    logic                    fetch;
    logic                    cin;
    logic [C_PCM_WIDTH-1:0]  sample;
    logic [C_PCM_WIDTH-1:0]  u;
    logic [C_PCM_WIDTH:0]    sum;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fill_act  = 1'b0;
        word_take = 1'b0;
        word_miss = 1'b0;
        if (!en_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = FILL;
                end
                FILL: begin
                    fill_act  = 1'b1;
                    word_miss = done_i;
                    if (bit_cnt == C_BIT_END) begin
                        state_nxt = READY;
                    end
                end
                READY: begin
                    if (done_i) begin
                        word_take = 1'b1;
                        state_nxt = FILL;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign pcm_ready_o = en_i & ~buf_valid;

    // A fetch on an empty buffer plays midscale; a sample arriving that same cycle waits for the next fetch.
    assign fetch  = (osr_cnt == '0);
    assign sample = fetch ? (buf_valid ? buf_dat : '0) : cur;
    assign u      = sample ^ C_SIGN;
    assign sum    = {1'b0, acc} + {1'b0, u} + {{C_PCM_WIDTH{1'b0}}, cin};

`ifdef PDM_PCM_MOD_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            lfsr <= 16'hACE1;
        end else if (fill_act) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign cin = lfsr[0];
`else
    assign cin = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            buf_valid       <= 1'b0;
            buf_dat         <= '0;
            cur             <= '0;
            acc             <= '0;
            osr_cnt         <= '0;
            bit_cnt         <= '0;
            staging         <= '0;
            data_o          <= C_MID;
            pcm_underrun_o  <= 1'b0;
            word_underrun_o <= 1'b0;
        end else begin
            if (pcm_valid_i && pcm_ready_o) begin
                buf_dat   <= pcm_data_i;
                buf_valid <= 1'b1;
            end
            if (fill_act) begin
                if (fetch) begin
                    cur <= sample;
                    if (buf_valid) begin
                        buf_valid <= 1'b0;
                    end else begin
                        pcm_underrun_o <= 1'b1;
                    end
                end
                acc     <= sum[C_PCM_WIDTH-1:0];
                staging <= {staging[C_NR_OF_BITS-2:0], sum[C_PCM_WIDTH]};
                osr_cnt <= (osr_cnt == C_OSR_END) ? '0 : osr_cnt + 1'b1;
                bit_cnt <= (bit_cnt == C_BIT_END) ? '0 : bit_cnt + 1'b1;
            end
            // The serializer still needs something to play if it outruns the fill.
            if (word_miss) begin
                data_o          <= C_MID;
                word_underrun_o <= 1'b1;
            end else if (word_take) begin
                data_o <= staging;
            end
        end
    end

endmodule

// File: tb/tb_pdm_pcm_mod.sv
// Directed bench for pdm_pcm_mod with the default build (no dither), N=32, PCM width 16, OSR 64.
module tb_pdm_pcm_mod;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic [15:0] pcm_data_i;
    logic        pcm_valid_i;
    logic        pcm_ready_o;
    logic        done_i;
    logic [31:0] data_o;
    logic        pcm_underrun_o;
    logic        word_underrun_o;

    int n_tests = 0;
    int n_fail  = 0;

    pdm_pcm_mod #(
        .C_NR_OF_BITS(32),
        .C_PCM_WIDTH (16),
        .C_OSR       (64)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .en_i           (en_i),
        .pcm_data_i     (pcm_data_i),
        .pcm_valid_i    (pcm_valid_i),
        .pcm_ready_o    (pcm_ready_o),
        .done_i         (done_i),
        .data_o         (data_o),
        .pcm_underrun_o (pcm_underrun_o),
        .word_underrun_o(word_underrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_done();
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        en_i        = 1'b0;
        pcm_data_i  = 16'h0000;
        pcm_valid_i = 1'b0;
        done_i      = 1'b0;
        ticks(2);
        check("rst_data", data_o, 32'h55555555);
        check("rst_ready", {31'd0, pcm_ready_o}, 32'd0);
        check("rst_pcm_uf", {31'd0, pcm_underrun_o}, 32'd0);
        check("rst_word_uf", {31'd0, word_underrun_o}, 32'd0);
        rst_i = 1'b0;
        tick();

        // No samples at all: midscale fetch and pcm underrun.
        en_i = 1'b1;
        tick();
        ticks(32);
        pulse_done();
        check("t1_word", data_o, 32'h55555555);
        check("t1_pcm_uf", {31'd0, pcm_underrun_o}, 32'd1);
        check("t1_word_uf", {31'd0, word_underrun_o}, 32'd0);

        // Zero sample buffered before the first fetch.
        en_i = 1'b0;
        tick();
        check("t2_flags_clr", {30'd0, pcm_underrun_o, word_underrun_o}, 32'd0);
        en_i        = 1'b1;
        pcm_valid_i = 1'b1;
        pcm_data_i  = 16'h0000;
        tick();
        pcm_valid_i = 1'b0;
        check("t2_ready_full", {31'd0, pcm_ready_o}, 32'd0);
        tick();
        check("t2_ready_back", {31'd0, pcm_ready_o}, 32'd1);
        ticks(31);
        pulse_done();
        check("t2_word1", data_o, 32'h55555555);
        ticks(32);
        pulse_done();
        check("t2_word2", data_o, 32'h55555555);
        check("t2_pcm_uf", {31'd0, pcm_underrun_o}, 32'd0);

        // Full-scale positive then full-scale negative.
        en_i = 1'b0;
        tick();
        en_i        = 1'b1;
        pcm_valid_i = 1'b1;
        pcm_data_i  = 16'h7FFF;
        tick();
        pcm_data_i = 16'h8000;
        ticks(2);
        pcm_valid_i = 1'b0;
        ticks(30);
        pulse_done();
        check("t3_word1", data_o, 32'h7FFFFFFF);
        ticks(32);
        pulse_done();
        check("t3_word2", data_o, 32'hFFFFFFFF);
        ticks(32);
        pulse_done();
        check("t3_word3", data_o, 32'h00000000);
        check("t3_pcm_uf", {31'd0, pcm_underrun_o}, 32'd0);

        // done_i arriving mid-fill.
        en_i = 1'b0;
        tick();
        en_i        = 1'b1;
        pcm_valid_i = 1'b1;
        pcm_data_i  = 16'h7FFF;
        tick();
        pcm_valid_i = 1'b0;
        ticks(9);
        pulse_done();
        check("t4_mid_data", data_o, 32'h55555555);
        check("t4_mid_uf", {31'd0, word_underrun_o}, 32'd1);
        ticks(22);
        pulse_done();
        check("t4_word", data_o, 32'h7FFFFFFF);
        check("t4_uf_sticky", {31'd0, word_underrun_o}, 32'd1);

        // en_i dropped mid-fill with a sample buffered.
        pcm_valid_i = 1'b1;
        pcm_data_i  = 16'h1234;
        tick();
        pcm_valid_i = 1'b0;
        ticks(3);
        en_i = 1'b0;
        tick();
        check("t5_ready", {31'd0, pcm_ready_o}, 32'd0);
        check("t5_flags", {30'd0, pcm_underrun_o, word_underrun_o}, 32'd0);
        check("t5_data", data_o, 32'h55555555);
        pulse_done();
        check("t5_idle_done", {31'd0, word_underrun_o}, 32'd0);
        en_i        = 1'b1;
        pcm_valid_i = 1'b1;
        pcm_data_i  = 16'h0000;
        tick();
        pcm_valid_i = 1'b0;
        ticks(32);
        pulse_done();
        check("t5_word", data_o, 32'h55555555);
        check("t5_pcm_uf", {31'd0, pcm_underrun_o}, 32'd0);

        // Streaming 0x4000 with a 1024-cycle serializer period: density 3/4.
        en_i = 1'b0;
        tick();
        en_i        = 1'b1;
        pcm_valid_i = 1'b1;
        pcm_data_i  = 16'h4000;
        tick();
        ticks(32);
        for (int w = 0; w < 4; w++) begin
            pulse_done();
            check($sformatf("t6_pop%0d", w), $countones(data_o), 32'd24);
            ticks(1023);
        end
        check("t6_word_uf", {31'd0, word_underrun_o}, 32'd0);
        check("t6_pcm_uf", {31'd0, pcm_underrun_o}, 32'd0);
        pcm_valid_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
